// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detecting, maskable, priority interrupt controller with req/ack/return handshake
module irq_controller #(
    parameter int NSRC = 4,
    parameter int N    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC-1:0]          irq_src,
    input  logic                     ExtlAck,
    input  logic                     ERet,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [N-1:0]             cfg_wdata,
    output logic [N-1:0]             cfg_rdata,
    output logic                     ExtIRQ,
    output logic [$clog2(NSRC)-1:0]  irq_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NSRC);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]      r_state;
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic            r_irq;
    logic            r_busy;
    logic [IDW-1:0]  r_id;
    logic [N-1:0]    r_rdata;

    logic [NSRC-1:0] w_rise;
    logic            w_wr_mask;
    logic            w_wr_pend;
    logic [NSRC-1:0] w_mask_nxt;
    logic [NSRC-1:0] w_pend_cfg;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_req;
    logic [IDW-1:0]  w_win;
    logic            w_ack;
    logic            w_keep;
    logic [N-1:0]    w_rdata;

    assign w_rise     = irq_src & ~r_src_q;
    assign w_wr_mask  = cfg_we && (cfg_addr == 2'd0);
    assign w_wr_pend  = cfg_we && (cfg_addr == 2'd1);
    assign w_mask_nxt = w_wr_mask ? cfg_wdata[NSRC-1:0] : r_mask;
    assign w_pend_cfg = w_wr_pend ? (r_pend & ~cfg_wdata[NSRC-1:0]) : r_pend;
    assign w_ack      = (r_state == S_REQ) && ExtlAck;
    assign w_ack_clr  = w_ack ? (NSRC'(1) << r_id) : '0;
    // A rising edge in the same cycle as any clear keeps the bit set
    assign w_pend_nxt = (w_pend_cfg & ~w_ack_clr) | w_rise;
    assign w_req      = r_pend & r_mask;
    // The outstanding request survives only if its source stays enabled and pending after this edge
    assign w_keep     = w_mask_nxt[r_id] & w_pend_nxt[r_id];

    always_comb begin
        w_win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win = IDW'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            2'd0: w_rdata[NSRC-1:0] = r_mask;
            2'd1: w_rdata[NSRC-1:0] = r_pend;
            2'd2: begin
                w_rdata[IDW-1:0] = r_id;
                w_rdata[IDW]     = r_busy;
            end
            default: w_rdata[1:0] = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
        end else begin
            r_src_q <= irq_src;
            r_pend  <= w_pend_nxt;
            r_mask  <= w_mask_nxt;
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req != '0) begin
                        r_state <= S_REQ;
                        r_irq   <= 1'b1;
                        r_id    <= w_win;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_state <= S_SERVICE;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (!w_keep) begin
                        r_state <= S_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (ERet) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_rdata = r_rdata;
    assign ExtIRQ    = r_irq;
    assign irq_id    = r_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and randomized checks of irq_controller against a behavioural model
module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_src;
    logic        ExtlAck;
    logic        ERet;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic [63:0] cfg_rdata;
    logic        ExtIRQ;
    logic [1:0]  irq_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit [3:0]  m_srcq, m_pend, m_mask;
    int        m_state;
    bit        m_irq, m_busy;
    int        m_id;
    bit [63:0] m_rd;

    irq_controller #(.NSRC(4), .N(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .ExtlAck   (ExtlAck),
        .ERet      (ERet),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ExtIRQ    (ExtIRQ),
        .irq_id    (irq_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [3:0] rise, nm, np;
        bit found;
        if (!reset) begin
            m_srcq = 0; m_pend = 0; m_mask = 0; m_state = 0;
            m_irq = 0; m_busy = 0; m_id = 0; m_rd = 0;
        end else begin
            case (cfg_addr)
                2'd0:    m_rd = 64'(m_mask);
                2'd1:    m_rd = 64'(m_pend);
                2'd2:    m_rd = 64'(m_busy) * 4 + 64'(m_id);
                default: m_rd = 64'(m_state);
            endcase
            rise   = irq_src & ~m_srcq;
            m_srcq = irq_src;
            nm = m_mask;
            np = m_pend;
            if (cfg_we && cfg_addr == 2'd0) nm = cfg_wdata[3:0];
            if (cfg_we && cfg_addr == 2'd1) np = np & ~cfg_wdata[3:0];
            if (m_state == 0) begin
                found = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && m_pend[i] && m_mask[i]) begin
                        found = 1; m_id = i;
                    end
                end
                if (found) begin m_state = 1; m_irq = 1; end
            end else if (m_state == 1) begin
                if (ExtlAck) begin
                    np[m_id] = 0; m_state = 2; m_irq = 0; m_busy = 1;
                end else if (!nm[m_id] || !(np[m_id] || rise[m_id])) begin
                    m_state = 0; m_irq = 0;
                end
            end else if (ERet) begin
                m_state = 0; m_busy = 0;
            end
            m_pend = np | rise;
            m_mask = nm;
        end
    endtask

    // one clock: advance model, let DUT take the edge, compare, drop one-cycle strobes
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("m_extirq", 64'(ExtIRQ), 64'(m_irq));
        check("m_irq_id", 64'(irq_id), 64'(m_id));
        check("m_busy", 64'(busy), 64'(m_busy));
        check("m_rdata", cfg_rdata, m_rd);
        ExtlAck = 0; ERet = 0; cfg_we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        cyc();
    endtask

    initial begin
        reset = 0; irq_src = 0; ExtlAck = 0; ERet = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;

        // 1: basic request / ack / return
        cyc();
        check("rst_extirq", 64'(ExtIRQ), 0);
        check("rst_id", 64'(irq_id), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_rdata", cfg_rdata, 0);
        reset = 1;
        wr(2'd0, 64'hF);
        irq_src = 4'h4; cyc();
        irq_src = 0; cfg_addr = 2'd1; cyc();
        check("t1_pend", cfg_rdata, 64'h4);
        check("t1_irq", 64'(ExtIRQ), 1);
        check("t1_id", 64'(irq_id), 2);
        ExtlAck = 1; cyc();
        check("t1_ack_irq", 64'(ExtIRQ), 0);
        check("t1_ack_busy", 64'(busy), 1);
        cfg_addr = 2'd1; cyc();
        check("t1_pend_clr", cfg_rdata, 0);
        cfg_addr = 2'd2; cyc();
        check("t1_inservice", cfg_rdata, 64'h6);
        ERet = 1; cyc();
        check("t1_eret_busy", 64'(busy), 0);
        cfg_addr = 2'd3; cyc();
        check("t1_status", cfg_rdata, 0);

        // 2: priority and re-request after return
        irq_src = 4'hA; cyc();
        irq_src = 0; cyc();
        check("t2_id", 64'(irq_id), 1);
        check("t2_irq", 64'(ExtIRQ), 1);
        ExtlAck = 1; cyc();
        ERet = 1; cyc();
        check("t2_gap_irq", 64'(ExtIRQ), 0);
        cyc();
        check("t2_rereq_irq", 64'(ExtIRQ), 1);
        check("t2_rereq_id", 64'(irq_id), 3);
        ExtlAck = 1; cyc();
        ERet = 1; cyc();

        // 3: masked source stays pending until enabled
        wr(2'd0, 64'h0);
        irq_src = 4'h1; cyc();
        irq_src = 0; cyc();
        check("t3_masked_irq", 64'(ExtIRQ), 0);
        cfg_addr = 2'd1; cyc();
        check("t3_pend", cfg_rdata, 64'h1);
        wr(2'd0, 64'h1);
        cyc();
        check("t3_irq", 64'(ExtIRQ), 1);
        check("t3_id", 64'(irq_id), 0);
        ExtlAck = 1; cyc();
        ERet = 1; cyc();

        // 4: withdraw on mask clear; W1C loses to simultaneous rise
        wr(2'd0, 64'hF);
        irq_src = 4'h4; cyc();
        irq_src = 0; cyc();
        check("t4_irq", 64'(ExtIRQ), 1);
        wr(2'd0, 64'h0);
        check("t4_withdraw", 64'(ExtIRQ), 0);
        cfg_addr = 2'd3; cyc();
        check("t4_status", cfg_rdata, 0);
        cfg_addr = 2'd1; cyc();
        check("t4_pend_kept", cfg_rdata, 64'h4);
        wr(2'd0, 64'hF);
        cyc();
        check("t4_rereq", 64'(ExtIRQ), 1);
        irq_src = 4'h4; wr(2'd1, 64'h4);
        irq_src = 0; cfg_addr = 2'd1; cyc();
        check("t4_set_wins", cfg_rdata, 64'h4);
        check("t4_still_req", 64'(ExtIRQ), 1);
        ExtlAck = 1; cyc();
        ERet = 1; cyc();

        // 5: ack ignored in SERVICE, rises only pend
        irq_src = 4'h4; cyc();
        irq_src = 0; cyc();
        ExtlAck = 1; cyc();
        ExtlAck = 1; cyc();
        check("t5_busy", 64'(busy), 1);
        irq_src = 4'h1; cyc();
        irq_src = 0; cfg_addr = 2'd1; cyc();
        check("t5_pend", cfg_rdata, 64'h1);
        check("t5_no_irq", 64'(ExtIRQ), 0);
        ERet = 1; cyc();
        cyc();
        check("t5_irq", 64'(ExtIRQ), 1);
        check("t5_id", 64'(irq_id), 0);
        ExtlAck = 1; cyc();

        // 6: reset during SERVICE with pending work, line held high through reset
        irq_src = 4'h6; cyc();
        irq_src = 4'h2; reset = 0; cyc();
        check("t6_irq", 64'(ExtIRQ), 0);
        check("t6_id", 64'(irq_id), 0);
        check("t6_busy", 64'(busy), 0);
        check("t6_rdata", cfg_rdata, 0);
        cfg_addr = 2'd1; cyc();
        reset = 1; cyc();
        check("t6_pend_zero", cfg_rdata, 0);
        cfg_addr = 2'd0; cyc();
        check("t6_mask_zero", cfg_rdata, 0);
        cfg_addr = 2'd1; cyc();
        check("t6_held_rise", cfg_rdata, 64'h2);
        irq_src = 0;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 2) == 0) irq_src = 4'($urandom_range(0, 15));
            ExtlAck   = ($urandom_range(0, 3) == 0);
            ERet      = ($urandom_range(0, 4) == 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = {$urandom, $urandom};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Multi-source external interrupt controller feeding the processor's single exception-request input. It sits beside `processor_arm`. It edge-detects up to NSRC peripheral interrupt lines, latches them as pending and masks them through a small configuration register port. It presents the highest-priority request on `ExtIRQ` and sequences the request → acknowledge (`ExtlAck`) → return (`ERet`) handshake so that only one interrupt is in service at a time.

## Interface
- NSRC, 4: number of interrupt sources; valid range 2..16. IDW = $clog2(NSRC) is derived.
- N, 64: configuration data width, matching the datapath word.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_src  in  NSRC  peripheral interrupt lines, rising-edge sensitive; bit 0 has the highest priority.
- ExtlAck  in  1  processor acknowledge, one-cycle pulse when the exception is taken.
- ERet  in  1  processor exception-return strobe, one cycle.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  register select: 0 MASK, 1 PENDING, 2 INSERVICE, 3 STATUS.
- cfg_wdata  in  N  write data.
- cfg_rdata  out  N  registered read data.
- ExtIRQ  out  1  registered interrupt request to the processor.
- irq_id  out  IDW  index of the requested or in-service source.
- busy  out  1  high while in state SERVICE.

## Operation
- Edge detect: src_q registers irq_src every cycle. rise = irq_src & ~src_q. Each rise bit sets the matching pending bit.
- MASK register (rw, low NSRC bits): a 1 enables the source. Reset value 0, so all sources are disabled.
- PENDING register: reads the pending bits. A write of 1 clears the bit; a write of 0 has no effect. If a rise and a clear hit the same bit in the same cycle, the set wins.
- INSERVICE register (read-only): {valid, irq_id}. valid = busy.
- STATUS register (read-only): bits[1:0] = state encoding (IDLE=0, REQ=1, SERVICE=2); bits[N-1:2] = 0.
- Writes to registers 2 and 3 are ignored. Unused upper bits read as 0.
- Arbitration: req_vec = pending & mask. The winner is the lowest set index.

State machine:
- IDLE:
  - If req_vec != 0, go to REQ. In the same edge, set ExtIRQ=1 and latch irq_id = winner.
- REQ:
  - irq_id is frozen. No re-arbitration, even if a higher-priority source becomes pending.
  - If mask[irq_id] becomes 0 (cfg write), go to IDLE with ExtIRQ=0. The pending bit is retained.
  - If pending[irq_id] is cleared by a cfg write, withdraw to IDLE in the same way.
  - On ExtlAck=1, go to SERVICE with ExtIRQ=0. Clear pending[irq_id], unless a new rise on that bit occurs in the same cycle (set wins).
- SERVICE:
  - busy=1 and irq_id is held.
  - New rises still set pending bits but are not requested.
  - On ERet=1, go to IDLE with busy=0.

Ignored inputs and other rules:
- ExtlAck outside REQ is ignored.
- ERet outside SERVICE is ignored.
- If ExtlAck and a mask-clear occur in the same cycle in REQ, the acknowledge wins and the state goes to SERVICE.
- There is no nesting. Priority affects only selection at the IDLE → REQ transition.

## Timing
- Reset (reset=0 sampled at an edge), all values after that edge:
  - state=IDLE; ExtIRQ=0, irq_id=0, busy=0, cfg_rdata=0.
  - mask=0, pending=0.
  - src_q=0, so a line held high through reset registers a rise on the first active cycle.
- Request latency:
  - Source sampled high at edge k (low at k-1) → pending set after edge k.
  - ExtIRQ=1 after edge k+1, if the source is unmasked and the state is IDLE.
- Acknowledge: ExtlAck sampled at edge a → ExtIRQ=0 and busy=1 after edge a.
- Return and re-request: ERet sampled at edge r → IDLE after r. A remaining enabled pending source raises ExtIRQ after edge r+1. The minimum gap between requests is therefore 1 idle cycle.
- Configuration write: takes effect after the edge on which cfg_we is sampled.
- Configuration read: cfg_rdata reflects cfg_addr and register contents as of the previous edge, so read latency is 1 cycle.
- ExtIRQ, irq_id and busy are driven from flops with no combinational path from any input.
- Reset mid-operation (any state): returns to the reset values above. In-flight pending bits and the in-service bit are lost.

## Test plan
1. Reset, write MASK=0xF, pulse irq_src[2] → pending=0x4 after 1 edge, ExtIRQ=1 and irq_id=2 one edge later. Then ExtlAck → ExtIRQ=0, busy=1, PENDING reads 0x0. Then ERet → busy=0, STATUS reads 0.
2. MASK=0xF, raise irq_src[3] and irq_src[1] in the same cycle → irq_id=1. After ExtlAck then ERet, ExtIRQ re-asserts with irq_id=3 one cycle after the return edge.
3. MASK=0x0, pulse irq_src[0] → ExtIRQ stays 0 and PENDING=0x1. Write MASK=0x1 → ExtIRQ=1, irq_id=0 one edge after the write.
4. In REQ with irq_id=2, write MASK=0x0 → ExtIRQ=0, state IDLE, pending[2] still 1. Repeat with a PENDING W1C of 0x4 in the same cycle as a new rise on irq_src[2] → pending[2] stays 1.
5. In SERVICE, pulse ExtlAck and then irq_src[0] → no state change and ExtIRQ=0, pending=0x1. After ERet, ExtIRQ=1 with irq_id=0.
6. Assert reset=0 during SERVICE with pending=0x6 → after that edge all outputs 0, PENDING and MASK read 0. A line held high through reset produces pending=1 on the first cycle after reset deasserts.
